// File: rtl/alt_write_sequencer.sv
// Two-source write sequencer feeding the alternating-write register: per-source FIFOs, read/write arbitration.
// Latency: a word pushed on edge N shows write_enable=1 after edge N+1 at the earliest; all outputs registered.
// Backpressure: sN_ready drops while that source FIFO is full; rd_req is held until rd_grant pulses.

module alt_write_sequencer_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    // Purpose: small circular FIFO with no bypass path.
    // Latency: a pushed word becomes the head one edge later.
    // Backpressure: caller must not push when full or pop when empty.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module alt_write_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s1_valid,
    input  logic [WIDTH-1:0]           s1_data,
    output logic                       s1_ready,
    input  logic                       s2_valid,
    input  logic [WIDTH-1:0]           s2_data,
    output logic                       s2_ready,
    input  logic                       rd_req,
    output logic                       rd_grant,
    output logic                       write_enable,
    output logic                       read_enable,
    output logic [WIDTH-1:0]           write_port_1,
    output logic [WIDTH-1:0]           write_port_2,
    output logic                       next_port,
    output logic [$clog2(DEPTH):0]     s1_count,
    output logic [$clog2(DEPTH):0]     s2_count,
    output logic [CW-1:0]              starve_cnt
);
    // Purpose: buffer two write sources and issue one read or write per cycle in port-1/port-2 order.
    // Latency: push on edge N, write_enable after edge N+1 at the earliest.
    // Backpressure: sN_ready = FIFO not full; reads wait for rd_grant.
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic             push1, push2, pop1, pop2;
    logic             empty1, empty2;
    logic [WIDTH-1:0] head1, head2;
    logic             wr_elig, issue_rd, issue_wr, starve_hit;

    assign s1_ready = (s1_count != CNTW'(DEPTH));
    assign s2_ready = (s2_count != CNTW'(DEPTH));
    assign push1    = s1_valid && s1_ready;
    assign push2    = s2_valid && s2_ready;
    assign empty1   = (s1_count == '0);
    assign empty2   = (s2_count == '0);

    alt_write_sequencer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push1),
        .push_dat (s1_data),
        .pop      (pop1),
        .head_dat (head1),
        .count    (s1_count)
    );

    alt_write_sequencer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push2),
        .push_dat (s2_data),
        .pop      (pop2),
        .head_dat (head2),
        .count    (s2_count)
    );

    // Only the FIFO owning the next port can supply a write; the other one just waits.
    assign wr_elig    = next_port ? !empty1 : !empty2;
    assign starve_hit = next_port ? (empty1 && !empty2) : (empty2 && !empty1);

    // read_enable is last cycle's op: a read never follows a read while a write is eligible.
    always_comb begin
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        if (rd_req && !read_enable) begin
            issue_rd = 1'b1;
        end else if (wr_elig) begin
            issue_wr = 1'b1;
        end else if (rd_req) begin
            issue_rd = 1'b1;
        end
    end

    assign pop1 = issue_wr && next_port;
    assign pop2 = issue_wr && !next_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            rd_grant     <= 1'b0;
            write_port_1 <= '0;
            write_port_2 <= '0;
            next_port    <= 1'b1;
            starve_cnt   <= '0;
        end else begin
            write_enable <= issue_wr;
            read_enable  <= issue_rd;
            rd_grant     <= issue_rd;
            if (issue_wr) begin
                if (next_port) begin
                    write_port_1 <= head1;
                end else begin
                    write_port_2 <= head2;
                end
                next_port <= !next_port;
            end
            if (starve_hit && (starve_cnt != {CW{1'b1}})) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alt_write_sequencer.sv
// Directed bench for alt_write_sequencer; a second instance with CW=2 shares the stimulus
// so its starvation counter can be watched saturating.
module tb_alt_write_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s1_valid, s2_valid, rd_req;
    logic [15:0] s1_data, s2_data;

    logic        s1_ready, s2_ready, rd_grant, write_enable, read_enable, next_port;
    logic [15:0] write_port_1, write_port_2;
    logic [2:0]  s1_count, s2_count;
    logic [7:0]  starve_cnt;

    logic        b_s1_ready, b_s2_ready, b_rd_grant, b_we, b_re, b_next_port;
    logic [15:0] b_wp1, b_wp2;
    logic [2:0]  b_s1_count, b_s2_count;
    logic [1:0]  b_starve;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alt_write_sequencer #(.WIDTH(16), .DEPTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .s2_valid(s2_valid), .s2_data(s2_data), .s2_ready(s2_ready),
        .rd_req(rd_req), .rd_grant(rd_grant),
        .write_enable(write_enable), .read_enable(read_enable),
        .write_port_1(write_port_1), .write_port_2(write_port_2),
        .next_port(next_port), .s1_count(s1_count), .s2_count(s2_count),
        .starve_cnt(starve_cnt)
    );

    alt_write_sequencer #(.WIDTH(16), .DEPTH(4), .CW(2)) dut_cw2 (
        .clk(clk), .rst(rst),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(b_s1_ready),
        .s2_valid(s2_valid), .s2_data(s2_data), .s2_ready(b_s2_ready),
        .rd_req(rd_req), .rd_grant(b_rd_grant),
        .write_enable(b_we), .read_enable(b_re),
        .write_port_1(b_wp1), .write_port_2(b_wp2),
        .next_port(b_next_port), .s1_count(b_s1_count), .s2_count(b_s2_count),
        .starve_cnt(b_starve)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            assert (!(read_enable && write_enable)) else begin
                n_fail++;
                $error("FAIL rd_wr_overlap: observed re=%b we=%b expected not both", read_enable, write_enable);
            end
        end
    end

    initial begin
        rst = 1'b1; s1_valid = 0; s2_valid = 0; rd_req = 0; s1_data = '0; s2_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_we", 32'(write_enable), 0);
        check("rst_re", 32'(read_enable), 0);
        check("rst_grant", 32'(rd_grant), 0);
        check("rst_np", 32'(next_port), 1);
        check("rst_c1", 32'(s1_count), 0);
        check("rst_c2", 32'(s2_count), 0);
        check("rst_wp1", 32'(write_port_1), 0);
        check("rst_wp2", 32'(write_port_2), 0);
        check("rst_starve", 32'(starve_cnt), 0);
        check("rst_rdy1", 32'(s1_ready), 1);

        // Simultaneous push on both sources: port1 then port2.
        s1_valid = 1; s1_data = 16'hAAAA; s2_valid = 1; s2_data = 16'h5555;
        tick();
        s1_valid = 0; s2_valid = 0;
        check("t1_push_c1", 32'(s1_count), 1);
        check("t1_push_c2", 32'(s2_count), 1);
        check("t1_push_we", 32'(write_enable), 0);
        tick();
        check("t1_w1_we", 32'(write_enable), 1);
        check("t1_w1_wp1", 32'(write_port_1), 32'hAAAA);
        check("t1_w1_np", 32'(next_port), 0);
        tick();
        check("t1_w2_we", 32'(write_enable), 1);
        check("t1_w2_wp2", 32'(write_port_2), 32'h5555);
        check("t1_w2_wp1_hold", 32'(write_port_1), 32'hAAAA);
        check("t1_w2_np", 32'(next_port), 1);
        tick();
        check("t1_idle_we", 32'(write_enable), 0);

        // Source 2 only: no write while port 1 is owed, starvation counts up.
        s2_valid = 1; s2_data = 16'h1111; tick();
        s2_data = 16'h2222; tick();
        s2_data = 16'h3333; tick();
        s2_valid = 0;
        check("t2_c2", 32'(s2_count), 3);
        check("t2_we", 32'(write_enable), 0);
        check("t2_starve2", 32'(starve_cnt), 2);
        check("t2_cw2_2", 32'(b_starve), 2);
        tick();
        check("t2_starve3", 32'(starve_cnt), 3);
        check("t2_cw2_3", 32'(b_starve), 3);
        tick();
        check("t2_starve4", 32'(starve_cnt), 4);
        check("t2_cw2_sat", 32'(b_starve), 3);
        tick();
        s1_valid = 1; s1_data = 16'h4444; tick();
        s1_valid = 0;
        check("t2_c1", 32'(s1_count), 1);
        check("t2_starve6", 32'(starve_cnt), 6);
        check("t2_cw2_sat6", 32'(b_starve), 3);
        tick();
        check("t2_w1_we", 32'(write_enable), 1);
        check("t2_w1_wp1", 32'(write_port_1), 32'h4444);
        check("t2_w1_np", 32'(next_port), 0);
        tick();
        check("t2_w2_we", 32'(write_enable), 1);
        check("t2_w2_wp2", 32'(write_port_2), 32'h1111);
        check("t2_w2_c2", 32'(s2_count), 2);
        tick();
        check("t2_stall_we", 32'(write_enable), 0);
        check("t2_starve7", 32'(starve_cnt), 7);

        // Reads against writes: alternation while rd_req is held.
        s1_valid = 1; s1_data = 16'hD001; tick();
        check("t4_starve8", 32'(starve_cnt), 8);
        s1_data = 16'hD002; tick();
        check("t4_wD001", 32'(write_port_1), 32'hD001);
        s1_data = 16'hD003; tick();
        check("t4_w2222", 32'(write_port_2), 32'h2222);
        s1_valid = 0; rd_req = 1;
        tick();
        check("t4_r1_re", 32'(read_enable), 1);
        check("t4_r1_grant", 32'(rd_grant), 1);
        check("t4_r1_we", 32'(write_enable), 0);
        tick();
        check("t4_w_we", 32'(write_enable), 1);
        check("t4_w_grant", 32'(rd_grant), 0);
        check("t4_w_wp1", 32'(write_port_1), 32'hD002);
        tick();
        check("t4_r2_re", 32'(read_enable), 1);
        check("t4_r2_grant", 32'(rd_grant), 1);
        tick();
        check("t4_w2_we", 32'(write_enable), 1);
        check("t4_w2_wp2", 32'(write_port_2), 32'h3333);
        rd_req = 0;
        tick();
        check("t4_w3_wp1", 32'(write_port_1), 32'hD003);
        check("t4_w3_c1", 32'(s1_count), 0);
        rd_req = 1;
        tick();
        check("t4_rr1_re", 32'(read_enable), 1);
        tick();
        check("t4_rr2_re", 32'(read_enable), 1);
        check("t4_rr2_grant", 32'(rd_grant), 1);
        rd_req = 0;
        tick();
        check("t4_idle_re", 32'(read_enable), 0);
        check("t4_idle_grant", 32'(rd_grant), 0);
        check("t4_starve_hold", 32'(starve_cnt), 8);

        // Reset while a write is issuing and both FIFOs hold two words.
        s1_valid = 1; s2_valid = 1; s1_data = 16'hE001; s2_data = 16'hF001; tick();
        s1_data = 16'hE002; s2_data = 16'hF002; tick();
        check("t5_wF001", 32'(write_port_2), 32'hF001);
        s1_data = 16'hE003; s2_data = 16'hF003; tick();
        s1_valid = 0; s2_valid = 0;
        check("t5_pre_we", 32'(write_enable), 1);
        check("t5_pre_c1", 32'(s1_count), 2);
        check("t5_pre_c2", 32'(s2_count), 2);
        rst = 1; tick(); rst = 0;
        check("t5_we", 32'(write_enable), 0);
        check("t5_np", 32'(next_port), 1);
        check("t5_c1", 32'(s1_count), 0);
        check("t5_c2", 32'(s2_count), 0);
        check("t5_wp1", 32'(write_port_1), 0);
        check("t5_starve", 32'(starve_cnt), 0);
        s1_valid = 1; s1_data = 16'hBEEF; tick();
        s1_valid = 0;
        tick();
        check("t5_beef_we", 32'(write_enable), 1);
        check("t5_beef_wp1", 32'(write_port_1), 32'hBEEF);
        check("t5_beef_wp2", 32'(write_port_2), 0);

        // Source 1 held with DEPTH+1 words, no source 2 traffic.
        rst = 1; tick(); rst = 0;
        s1_valid = 1; s1_data = 16'hC000; tick();
        s1_data = 16'hC001; tick();
        check("t3_first_we", 32'(write_enable), 1);
        check("t3_first_wp1", 32'(write_port_1), 32'hC000);
        s1_data = 16'hC002; tick();
        s1_data = 16'hC003; tick();
        s1_data = 16'hC004; tick();
        check("t3_full_c1", 32'(s1_count), 4);
        check("t3_full_rdy", 32'(s1_ready), 0);
        check("t3_starve3", 32'(starve_cnt), 3);
        s1_data = 16'hC005; tick();
        tick();
        check("t3_hold_c1", 32'(s1_count), 4);
        check("t3_hold_we", 32'(write_enable), 0);
        check("t3_starve5", 32'(starve_cnt), 5);
        check("t3_cw2_sat", 32'(b_starve), 3);
        s2_valid = 1; s2_data = 16'h7777; tick();
        s2_valid = 0;
        check("t3_starve6", 32'(starve_cnt), 6);
        tick();
        check("t3_w7777", 32'(write_port_2), 32'h7777);
        check("t3_c1_still", 32'(s1_count), 4);
        tick();
        s1_valid = 0;
        check("t3_order_wp1", 32'(write_port_1), 32'hC001);
        check("t3_c1_drain", 32'(s1_count), 3);
        check("t3_rdy_back", 32'(s1_ready), 1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
